// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction issue handshake bundle
//
// Purpose: carries MIPS instruction words from the fetch side into alu_issue.
// Signals:
//   in_valid  fetch -> issue : instruction offered
//   in_ready  issue -> fetch : instruction accepted at this edge
//   in_instr  fetch -> issue : 32-bit instruction word
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue stage feeding a single-cycle registered ALU
//
// Purpose: decodes R-type / I-type ALU instructions held in the I slot into
// operands and func for the ALU, forwards the in-flight ALU result to a
// dependent instruction, and tracks the one-cycle ALU latency in the X slot
// so writeback valid/address/data line up with the ALU output.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_if (slave)            instruction valid/ready/word
//   flush_i                  kill all in-flight instructions at this edge
//   rs_addr_o, rt_addr_o     register-file read addresses (combinational read)
//   rs_data_i, rt_data_i     register-file read data
//   operand_a_o, operand_b_o ALU operands
//   func_o                   ALU function code
//   alu_result_i             registered ALU output
//   wb_valid_o, wb_addr_o    writeback enable / destination
//   wb_data_o                writeback data (alu_result pass-through)
//   illegal_o                pulse in the writeback slot of an undecodable op
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  in_if,
  input  logic        flush_i,
  output logic [4:0]  rs_addr_o,
  output logic [4:0]  rt_addr_o,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [5:0]  func_o,
  input  logic [31:0] alu_result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        illegal_o
);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;

  logic        i_valid_q, i_valid_d;
  logic [31:0] i_instr_q, i_instr_d;
  logic        x_valid_q, x_valid_d;
  logic [4:0]  x_dest_q, x_dest_d;
  logic        x_illegal_q, x_illegal_d;

  logic        accept;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rd;
  logic [15:0] imm;
  logic        fwd_rs, fwd_rt;
  logic [31:0] rs_val, rt_val;
  logic [5:0]  dec_func;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_dest;
  logic        dec_illegal;

  assign in_if.in_ready = !flush_i;
  assign accept         = in_if.in_valid && !flush_i;

  assign opcode    = i_instr_q[31:26];
  assign rs_addr_o = i_instr_q[25:21];
  assign rt_addr_o = i_instr_q[20:16];
  assign rd        = i_instr_q[15:11];
  assign shamt     = i_instr_q[10:6];
  assign funct     = i_instr_q[5:0];
  assign imm       = i_instr_q[15:0];

  // $0 is never written, so a pending result aimed at it must not forward.
  assign fwd_rs = x_valid_q && !x_illegal_q && (x_dest_q != 5'd0) && (x_dest_q == rs_addr_o);
  assign fwd_rt = x_valid_q && !x_illegal_q && (x_dest_q != 5'd0) && (x_dest_q == rt_addr_o);
  assign rs_val = fwd_rs ? alu_result_i : rs_data_i;
  assign rt_val = fwd_rt ? alu_result_i : rt_data_i;

  always_comb begin
    dec_func    = F_OR;
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_dest    = 5'd0;
    dec_illegal = 1'b0;
    if (opcode == 6'b000000) begin
      dec_dest = rd;
      dec_func = funct;
      case (funct)
        6'b000000, 6'b000010, 6'b000011: begin
          dec_a = {27'd0, shamt};
          dec_b = rt_val;
        end
        6'b000100, 6'b000110, 6'b000111: begin
          // Variable shifts: the ALU only ever sees a 0..31 amount.
          dec_a = {27'd0, rs_val[4:0]};
          dec_b = rt_val;
        end
        6'b100000, 6'b100001, 6'b100010, 6'b100011,
        6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
          dec_a = rs_val;
          dec_b = rt_val;
        end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      dec_dest = rt_addr_o;
      dec_a    = rs_val;
      case (opcode)
        6'b001000, 6'b001001: begin
          dec_func = F_ADD;
          dec_b    = {{16{imm[15]}}, imm};
        end
        6'b001100: begin
          dec_func = F_AND;
          dec_b    = {16'd0, imm};
        end
        6'b001101: begin
          dec_func = F_OR;
          dec_b    = {16'd0, imm};
        end
        6'b001110: begin
          dec_func = F_XOR;
          dec_b    = {16'd0, imm};
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Bubbles and illegal ops present a harmless OR of zeros to the ALU.
  always_comb begin
    if (i_valid_q && !dec_illegal) begin
      func_o      = dec_func;
      operand_a_o = dec_a;
      operand_b_o = dec_b;
    end else begin
      func_o      = F_OR;
      operand_a_o = 32'd0;
      operand_b_o = 32'd0;
    end
  end

  always_comb begin
    i_valid_d   = accept;
    i_instr_d   = accept ? in_if.in_instr : i_instr_q;
    x_valid_d   = i_valid_q && !flush_i;
    x_dest_d    = dec_dest;
    x_illegal_d = dec_illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_valid_q   <= 1'b0;
      i_instr_q   <= 32'd0;
      x_valid_q   <= 1'b0;
      x_dest_q    <= 5'd0;
      x_illegal_q <= 1'b0;
    end else begin
      i_valid_q   <= i_valid_d;
      i_instr_q   <= i_instr_d;
      x_valid_q   <= x_valid_d;
      x_dest_q    <= x_dest_d;
      x_illegal_q <= x_illegal_d;
    end
  end

  assign wb_valid_o = x_valid_q && !x_illegal_q && (x_dest_q != 5'd0);
  assign wb_addr_o  = x_dest_q;
  assign wb_data_o  = alu_result_i;
  assign illegal_o  = x_valid_q && x_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
//
// Purpose: drives hand-encoded MIPS instructions into alu_issue with a
// bench-side register file and registered ALU, and compares operands, func
// and writeback against hand-computed values.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] op_a, op_b;
  logic [5:0]  func;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  logic        poke_en;
  logic [4:0]  poke_addr;
  logic [31:0] poke_data;
  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_if in_if();

  alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (in_if),
    .flush_i      (flush),
    .rs_addr_o    (rs_addr),
    .rt_addr_o    (rt_addr),
    .rs_data_i    (rs_data),
    .rt_data_i    (rt_data),
    .operand_a_o  (op_a),
    .operand_b_o  (op_b),
    .func_o       (func),
    .alu_result_i (alu_result),
    .wb_valid_o   (wb_valid),
    .wb_addr_o    (wb_addr),
    .wb_data_o    (wb_data),
    .illegal_o    (illegal)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (poke_en) begin
      rf[poke_addr] <= poke_data;
    end else if (wb_valid) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  always @(posedge clk) begin
    case (func)
      6'b000000:            alu_result <= op_b << op_a;
      6'b000010:            alu_result <= op_b >> op_a;
      6'b000011:            alu_result <= 32'($signed(op_b) >>> op_a);
      6'b000100:            alu_result <= op_b << op_a;
      6'b000110:            alu_result <= op_b >> op_a;
      6'b000111:            alu_result <= 32'($signed(op_b) >>> op_a);
      6'b100000, 6'b100001: alu_result <= op_a + op_b;
      6'b100010, 6'b100011: alu_result <= op_a - op_b;
      6'b100100:            alu_result <= op_a & op_b;
      6'b100101:            alu_result <= op_a | op_b;
      6'b100110:            alu_result <= op_a ^ op_b;
      6'b100111:            alu_result <= ~(op_a | op_b);
      default:              alu_result <= 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic drive(input logic [31:0] instr);
    in_if.in_valid = 1'b1;
    in_if.in_instr = instr;
  endtask

  task automatic idle();
    in_if.in_valid = 1'b0;
    in_if.in_instr = 32'd0;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    poke_en   = 1'b0;
    poke_addr = 5'd0;
    poke_data = 32'd0;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_func", 32'(func), 32'h25);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_rs_addr", 32'(rs_addr), 32'd0);
    check("rst_rt_addr", 32'(rt_addr), 32'd0);
    check("rst_in_ready", 32'(in_if.in_ready), 32'd1);
    flush = 1'b1;
    #1;
    check("rst_in_ready_flush", 32'(in_if.in_ready), 32'd0);
    flush = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // addi $3,$1,-1 with $1 = 5
    poke(5'd1, 32'd5);
    drive(itype(6'b001000, 5'd1, 5'd3, 16'hFFFF));
    tick();
    idle();
    check("addi_op_a", op_a, 32'd5);
    check("addi_op_b", op_b, 32'hFFFF_FFFF);
    check("addi_func", 32'(func), 32'h20);
    tick();
    check("addi_wb_valid", 32'(wb_valid), 32'd1);
    check("addi_wb_addr", 32'(wb_addr), 32'd3);
    check("addi_wb_data", wb_data, 32'd4);
    tick();
    check("addi_wb_done", 32'(wb_valid), 32'd0);

    // add $2,$1,$1 ; sub $4,$2,$1 ; xor $17,$1,$4 back-to-back, $1 = 7
    poke(5'd1, 32'd7);
    drive(rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'b100000));
    tick();
    check("fwd_add_op_a", op_a, 32'd7);
    drive(rtype(5'd2, 5'd1, 5'd4, 5'd0, 6'b100010));
    tick();
    drive(rtype(5'd1, 5'd4, 5'd17, 5'd0, 6'b100110));
    check("fwd_sub_op_a", op_a, 32'd14);
    check("fwd_sub_op_b", op_b, 32'd7);
    check("fwd_add_wb_addr", 32'(wb_addr), 32'd2);
    check("fwd_add_wb_data", wb_data, 32'd14);
    tick();
    idle();
    check("fwd_xor_op_b", op_b, 32'd7);
    check("fwd_sub_wb_addr", 32'(wb_addr), 32'd4);
    check("fwd_sub_wb_data", wb_data, 32'd7);
    tick();
    check("fwd_xor_wb_addr", 32'(wb_addr), 32'd17);
    check("fwd_xor_wb_data", wb_data, 32'd0);
    tick();

    // srav $5,$6,$7 with $7 = 0x23, $6 = 0x80000000
    poke(5'd7, 32'h23);
    poke(5'd6, 32'h8000_0000);
    drive(rtype(5'd7, 5'd6, 5'd5, 5'd0, 6'b000111));
    tick();
    idle();
    check("srav_op_a", op_a, 32'd3);
    check("srav_op_b", op_b, 32'h8000_0000);
    check("srav_func", 32'(func), 32'h07);
    tick();
    check("srav_wb_addr", 32'(wb_addr), 32'd5);
    check("srav_wb_data", wb_data, 32'hF000_0000);
    tick();

    // sll $8,$9,31 with $9 = 1
    poke(5'd9, 32'd1);
    drive(rtype(5'd0, 5'd9, 5'd8, 5'd31, 6'b000000));
    tick();
    idle();
    check("sll_op_a", op_a, 32'd31);
    tick();
    check("sll_wb_valid", 32'(wb_valid), 32'd1);
    check("sll_wb_data", wb_data, 32'h8000_0000);
    tick();

    // lui is undecodable
    drive(itype(6'b001111, 5'd0, 5'd10, 16'h1234));
    tick();
    idle();
    check("lui_func", 32'(func), 32'h25);
    check("lui_op_b", op_b, 32'd0);
    tick();
    check("lui_illegal", 32'(illegal), 32'd1);
    check("lui_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("lui_illegal_pulse", 32'(illegal), 32'd0);

    // add $0,$1,$1 then add $11,$0,$1 with $1 = 3
    poke(5'd1, 32'd3);
    drive(rtype(5'd1, 5'd1, 5'd0, 5'd0, 6'b100000));
    tick();
    drive(rtype(5'd0, 5'd1, 5'd11, 5'd0, 6'b100000));
    tick();
    idle();
    check("r0_wb_valid", 32'(wb_valid), 32'd0);
    check("r0_no_fwd_op_a", op_a, 32'd0);
    check("r0_op_b", op_b, 32'd3);
    tick();
    check("r0_next_wb_addr", 32'(wb_addr), 32'd11);
    check("r0_next_wb_data", wb_data, 32'd3);
    tick();

    // Flush with both slots full and a new instruction offered
    drive(rtype(5'd1, 5'd1, 5'd12, 5'd0, 6'b100000));
    tick();
    drive(itype(6'b001111, 5'd0, 5'd13, 16'h0001));
    tick();
    flush = 1'b1;
    drive(rtype(5'd1, 5'd1, 5'd14, 5'd0, 6'b100000));
    #1;
    check("flush_in_ready", 32'(in_if.in_ready), 32'd0);
    check("flush_x_wb_valid", 32'(wb_valid), 32'd1);
    check("flush_x_wb_addr", 32'(wb_addr), 32'd12);
    check("flush_x_wb_data", wb_data, 32'd6);
    tick();
    flush = 1'b0;
    idle();
    check("flush_after_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_after_illegal", 32'(illegal), 32'd0);
    check("flush_after_func", 32'(func), 32'h25);
    tick();
    check("flush_late_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_late_illegal", 32'(illegal), 32'd0);
    tick();

    // Asynchronous reset mid-cycle with both slots full
    poke(5'd1, 32'd3);
    drive(rtype(5'd1, 5'd1, 5'd15, 5'd0, 6'b100000));
    tick();
    drive(itype(6'b001111, 5'd0, 5'd16, 16'h0002));
    tick();
    idle();
    check("arst_pre_wb_valid", 32'(wb_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_illegal", 32'(illegal), 32'd0);
    check("arst_func", 32'(func), 32'h25);
    check("arst_op_a", op_a, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_after_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_after_illegal", 32'(illegal), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that drives the core's single-cycle registered ALU. It accepts MIPS instruction words over a valid/ready handshake, reads two source registers from the register file and decodes R-type and I-type ALU instructions into `operand_a`/`operand_b`/`func`. It forwards the in-flight ALU result to a dependent instruction and tracks the ALU's one-cycle result latency, so writeback valid, address and data line up with the ALU output.

## Interface
- No parameters; data width fixed at 32, register address 5.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: block accepts the instruction at this edge.
- `in_instr` in 32: MIPS instruction word.
- `flush` in 1: synchronous kill of all in-flight instructions.
- `rs_addr`, `rt_addr` out 5: register-file read addresses; the read is combinational.
- `rs_data`, `rt_data` in 32: register-file read data; no write-through.
- `operand_a`, `operand_b` out 32: to the ALU.
- `func` out 6: to the ALU.
- `alu_result` in 32: registered ALU output.
- `wb_valid` out 1: write `wb_data` to `wb_addr` at the edge ending this cycle.
- `wb_addr` out 5: writeback destination register.
- `wb_data` out 32: equals `alu_result` (combinational pass-through).
- `illegal` out 1: one-cycle pulse in the writeback slot of an undecodable instruction.

## Operation
- **Pipeline slots.**
  - I slot holds `i_valid` and `i_instr`.
  - X slot holds `x_valid`, `x_dest` and `x_illegal`; it mirrors the instruction the ALU is currently computing.
- **Handshake.**
  - `in_ready = !flush`.
  - On `in_valid && in_ready`, `i_instr <= in_instr` and `i_valid <= 1`; otherwise `i_valid <= 0`.
  - Every edge, the X slot takes the I slot's decoded `dest`, `illegal` and `i_valid`.
- **Decode (I slot, combinational).**
  - `rs_addr = instr[25:21]`, `rt_addr = instr[20:16]`.
- **R-type (opcode 000000).** `func = instr[5:0]`; `dest = rd` (`instr[15:11]`).
  - sll/srl/sra (000000/000010/000011): `operand_a = {27'b0, shamt}`, `operand_b = rt`.
  - sllv/srlv/srav (000100/000110/000111): `operand_a = {27'b0, rs[4:0]}`, `operand_b = rt`. The shift amount is masked to 5 bits.
  - add/addu/sub/subu/and/or/xor/nor (100000–100111): `operand_a = rs`, `operand_b = rt`.
  - Any other funct is illegal.
- **I-type.** `dest = rt`; `operand_a = rs`.
  - addi/addiu (001000/001001): `func = 100000`, `operand_b` sign-extended `imm16`.
  - andi (001100): `func = 100100`, `operand_b` zero-extended `imm16`.
  - ori (001101): `func = 100101`, `operand_b` zero-extended `imm16`.
  - xori (001110): `func = 100110`, `operand_b` zero-extended `imm16`.
  - All other opcodes are illegal.
- **Bubble or illegal in I slot.** Drive `func = 100101`, `operand_a = operand_b = 0`, so the ALU never sees an unmapped func.
- **Forwarding.**
  - The rs value is replaced by `alu_result` when `x_valid && !x_illegal && x_dest != 0 && x_dest == rs_addr`.
  - The rt value uses the same rule with `rt_addr`.
  - The forwarded value is used before the shift mask and before operand selection.
- **Writeback.**
  - `wb_valid = x_valid && !x_illegal && x_dest != 0`.
  - `wb_addr = x_dest`.
  - `illegal = x_valid && x_illegal`.
- **Flush.** At the edge with `flush = 1`, `i_valid` and `x_valid` clear. The instruction currently in the X slot still writes back during the flush cycle.

## Timing
- **Reset values.**
  - Internal: `i_valid`, `x_valid`, `x_illegal` = 0; `i_instr`, `x_dest` = 0.
  - Outputs: `wb_valid` = 0, `illegal` = 0, `wb_addr` = 0, `func` = 100101, `operand_a` = 0, `operand_b` = 0, `rs_addr` = 0, `rt_addr` = 0.
  - `in_ready` follows `flush` and is not gated by reset.
- **Latency and throughput.**
  - Instruction accepted at edge E0 → operands driven in cycle E0–E1 → ALU captures at E1 → `wb_valid` high in cycle E1–E2 → register file writes at E2.
  - Throughput is one instruction per cycle.
- **Back-to-back dependency.**
  - Distance 1 is covered by forwarding.
  - Distance 2 reads the register file after its write at E2.
  - No stalls exist.
- **Reset mid-operation.** All slots clear immediately; no writeback or illegal pulse is produced for in-flight instructions.
- **Flush with `in_valid`.** The instruction is not accepted because `in_ready = 0`.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle with both slots full → `wb_valid`, `illegal` and `i_valid` drop immediately; `func = 100101`, operands = 0.
- **addi.** `addi $3,$1,-1` with `$1 = 5` → in the issue cycle `operand_b = 0xFFFFFFFF`, `func = 100000`; two edges after acceptance `wb_valid = 1`, `wb_addr = 3`, `wb_data = 4`.
- **Forwarding.** `add $2,$1,$1` (`$1 = 7`) then `sub $4,$2,$1` back-to-back → the second instruction's `operand_a = 14` from `alu_result`, not stale `rs_data`; `wb_data = 7` for `$4`.
- **Shift masking.** `srav $5,$6,$7` with `$7 = 0x23`, `$6 = 0x80000000` → `operand_a = 3`, `wb_data = 0xF0000000`. `sll` with shamt 31 on `rt = 1` → `wb_data = 0x80000000`.
- **Illegal and $0.** `lui` (opcode 001111) → `illegal` pulses 1 cycle and `wb_valid = 0`. `add $0,$1,$1` → `wb_valid = 0`, and the next instruction reading `$0` gets `rs_data` with no forwarding.
- **Flush.** Assert `flush` with `in_valid` high and both slots full → `in_ready = 0`, X-slot writeback still completes that cycle, and no writeback or illegal follows for the flushed I-slot instruction.
